// File: rtl/wb_sideband_pipe.sv
// EX->WB delay line for side-channel write-back results: NCH independent channels of DEPTH
// stages with stall, flush, per-channel in-flight counts and a youngest-value bypass.
module wb_sideband_pipe #(
  parameter  int NCH   = 4,
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_we,
  output logic [NCH*W-1:0]  wb_data,
  output logic [NCH-1:0]    wb_we,
  output logic [NCH-1:0]    byp_valid,
  output logic [NCH*W-1:0]  byp_data,
  output logic [NCH*CW-1:0] pending
);

  if (DEPTH < 1 || NCH < 1 || W < 1) begin : g_param_check
    $error("wb_sideband_pipe: NCH, W and DEPTH must all be >= 1");
  end

  // Stage 0 is the youngest; stage DEPTH-1 feeds write-back.
  logic [NCH*W-1:0] data_q [DEPTH];
  logic [NCH*W-1:0] data_d [DEPTH];
  logic [NCH-1:0]   we_q   [DEPTH];
  logic [NCH-1:0]   we_d   [DEPTH];

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = data_q[k];
      we_d[k]   = we_q[k];
    end
    if (flush) begin
      // Flush cancels writes but leaves data alone; it also wins over stall.
      for (int k = 0; k < DEPTH; k++) we_d[k] = '0;
    end else if (!stall) begin
      data_d[0] = in_data;
      we_d[0]   = in_we;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        we_d[k]   = we_q[k-1];
      end
    end
  end

  // NOTE: state is written with non-blocking assignments so every stage samples the pre-edge
  // value of its neighbour. The data stages are reset too (not left as an unreset array)
  // because wb_data and byp_data must read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        we_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
        we_q[k]   <= we_d[k];
      end
    end
  end

  // A stalled final stage is held, not written, so its strobe is masked until stall drops.
  assign wb_data = data_q[DEPTH-1];
  assign wb_we   = we_q[DEPTH-1] & ~{NCH{stall}};

  always_comb begin
    pending   = '0;
    byp_valid = '0;
    byp_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      // Walk oldest to youngest so the youngest valid stage is the last to overwrite.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        pending[i*CW +: CW] = pending[i*CW +: CW] + CW'(we_q[k][i]);
        if (we_q[k][i]) begin
          byp_valid[i]       = 1'b1;
          byp_data[i*W +: W] = data_q[k][i*W +: W];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_sideband_pipe.sv
// Directed bench for wb_sideband_pipe: DEPTH=2 directed checks plus DEPTH=1/DEPTH=4 streams
// compared against a scoreboard queue of expected write-backs.
module tb_wb_sideband_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DEPTH=2 instance
  logic         rst_a, stall, flush;
  logic [127:0] in_data, wb_data, byp_data;
  logic [3:0]   in_we, wb_we, byp_valid;
  logic [7:0]   pending;

  wb_sideband_pipe #(.NCH(4), .W(32), .DEPTH(2)) u_dut (
    .clk(clk), .reset(rst_a), .stall(stall), .flush(flush),
    .in_data(in_data), .in_we(in_we),
    .wb_data(wb_data), .wb_we(wb_we), .byp_valid(byp_valid),
    .byp_data(byp_data), .pending(pending)
  );

  // Streaming DEPTH=1 and DEPTH=4 instances sharing one stimulus
  logic         rst_b;
  logic         s_idle = 1'b0;
  logic [127:0] s_data;
  logic [3:0]   s_we;
  logic [127:0] d1_wb_data, d1_byp_data, d4_wb_data, d4_byp_data;
  logic [3:0]   d1_wb_we, d1_byp_valid, d4_wb_we, d4_byp_valid;
  logic [3:0]   d1_pending;
  logic [11:0]  d4_pending;

  wb_sideband_pipe #(.NCH(4), .W(32), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(rst_b), .stall(s_idle), .flush(s_idle),
    .in_data(s_data), .in_we(s_we),
    .wb_data(d1_wb_data), .wb_we(d1_wb_we), .byp_valid(d1_byp_valid),
    .byp_data(d1_byp_data), .pending(d1_pending)
  );

  wb_sideband_pipe #(.NCH(4), .W(32), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(rst_b), .stall(s_idle), .flush(s_idle),
    .in_data(s_data), .in_we(s_we),
    .wb_data(d4_wb_data), .wb_we(d4_wb_we), .byp_valid(d4_byp_valid),
    .byp_data(d4_byp_data), .pending(d4_pending)
  );

  typedef struct {
    int           due;
    logic [127:0] data;
  } sb_t;
  sb_t q1[$];
  sb_t q4[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ch(input int i, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] we, input logic [127:0] d, input logic st, input logic fl);
    in_we   = we;
    in_data = d;
    stall   = st;
    flush   = fl;
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wb_we"},     wb_we,     '0);
    check({tag, "_wb_data"},   wb_data,   '0);
    check({tag, "_byp_valid"}, byp_valid, '0);
    check({tag, "_byp_data"},  byp_data,  '0);
    check({tag, "_pending"},   pending,   '0);
  endtask

  // Scoreboard monitors: every strobe must match the oldest queued write and its due cycle.
  always @(negedge clk) begin
    if (d1_wb_we !== 4'h0) begin
      if (q1.size() == 0) check("d1_unexpected_we", d1_wb_we, 4'h0);
      else begin
        sb_t e;
        e = q1.pop_front();
        check("d1_sb_we",    d1_wb_we,   4'hF);
        check("d1_sb_data",  d1_wb_data, e.data);
        check("d1_sb_cycle", cyc,        e.due);
      end
    end
    if (d4_wb_we !== 4'h0) begin
      if (q4.size() == 0) check("d4_unexpected_we", d4_wb_we, 4'h0);
      else begin
        sb_t e;
        e = q4.pop_front();
        check("d4_sb_we",    d4_wb_we,   4'hF);
        check("d4_sb_data",  d4_wb_data, e.data);
        check("d4_sb_cycle", cyc,        e.due);
      end
    end
  end

  task automatic stream(input int n);
    logic [127:0] prev;
    prev = '0;
    for (int c = 0; c < n; c++) begin
      s_we   = 4'hF;
      s_data = {$urandom, $urandom, $urandom, $urandom};
      q1.push_back('{due: cyc + 1, data: s_data});
      q4.push_back('{due: cyc + 4, data: s_data});
      #1;
      if (c >= 4) begin
        check("d4_pending_sat", d4_pending,   12'h924);
        check("d4_byp_valid",   d4_byp_valid, 4'hF);
        check("d4_byp_data",    d4_byp_data,  prev);
        check("d1_pending_sat", d1_pending,   4'hF);
        check("d1_byp_data",    d1_byp_data,  prev);
      end
      prev = s_data;
      next_cycle();
    end
    s_we = 4'h0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    stall = 1'b0; flush = 1'b0; in_we = '0; in_data = '0;
    s_we  = '0;   s_data = '0;

    // 1: outputs stay zero under reset with random inputs, and one cycle after release
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom));
      check_zero("t1_in_reset");
    end
    next_cycle();
    rst_a = 1'b0;
    drive('0, '0, 0, 0);
    check_zero("t1_release");
    next_cycle();
    drive('0, '0, 0, 0);
    check_zero("t1_after");

    // 2: single write on ch1, DEPTH-cycle latency
    next_cycle(); drive(4'b0010, ch(1, 32'hDEADBEEF), 0, 0);
    check("t2_c0_we", wb_we, 4'b0000);
    next_cycle(); drive('0, '0, 0, 0);
    check("t2_c1_pending", pending, 8'h04);
    check("t2_c1_bypv",    byp_valid, 4'b0010);
    check("t2_c1_bypd",    byp_data, ch(1, 32'hDEADBEEF));
    check("t2_c1_we",      wb_we, 4'b0000);
    next_cycle(); drive('0, '0, 0, 0);
    check("t2_c2_we",      wb_we, 4'b0010);
    check("t2_c2_data",    wb_data, ch(1, 32'hDEADBEEF));
    check("t2_c2_pending", pending, 8'h04);
    check("t2_c2_bypd",    byp_data, ch(1, 32'hDEADBEEF));
    next_cycle(); drive('0, '0, 0, 0);
    check("t2_c3_we",      wb_we, 4'b0000);
    check("t2_c3_pending", pending, 8'h00);

    // 3: stall in cycle 1 delays the write by one cycle and drops the stalled input
    next_cycle(); drive(4'b0010, ch(1, 32'hDEADBEEF), 0, 0);
    next_cycle(); drive(4'hF, {4{32'h5555_5555}}, 1, 0);
    check("t3_c1_we", wb_we, 4'b0000);
    next_cycle(); drive('0, '0, 0, 0);
    check("t3_c2_we",      wb_we, 4'b0000);
    check("t3_c2_pending", pending, 8'h04);
    check("t3_c2_bypd",    byp_data, ch(1, 32'hDEADBEEF));
    next_cycle(); drive('0, '0, 0, 0);
    check("t3_c3_we",   wb_we, 4'b0010);
    check("t3_c3_data", wb_data, ch(1, 32'hDEADBEEF));
    next_cycle(); drive('0, '0, 0, 0);
    check("t3_c4_we",      wb_we, 4'b0000);
    check("t3_c4_pending", pending, 8'h00);

    // 3b: stall while the final stage is valid masks the strobe; the write follows afterwards
    next_cycle(); drive(4'b0100, ch(2, 32'h3333_3333), 0, 0);
    next_cycle(); drive('0, '0, 0, 0);
    check("t3b_c1_pending", pending, 8'h10);
    next_cycle(); drive('0, '0, 1, 0);
    check("t3b_c2_we",   wb_we, 4'b0000);
    check("t3b_c2_data", wb_data, ch(2, 32'h3333_3333));
    next_cycle(); drive('0, '0, 0, 0);
    check("t3b_c3_we", wb_we, 4'b0100);
    next_cycle(); drive('0, '0, 0, 0);
    check("t3b_c4_we", wb_we, 4'b0000);

    // 4: flush (alone, then with stall) cancels both in-flight and incoming writes
    for (int m = 0; m < 2; m++) begin
      next_cycle(); drive(4'b0001, ch(0, 32'h11), 0, 0);
      next_cycle(); drive(4'b0001, ch(0, 32'h22), 1'(m), 1);
      check("t4_c1_we", wb_we, 4'b0000);
      next_cycle(); drive('0, '0, 0, 0);
      check("t4_c2_we",      wb_we, 4'b0000);
      check("t4_c2_pending", pending, 8'h00);
      check("t4_c2_bypv",    byp_valid, 4'b0000);
      check("t4_c2_bypd",    byp_data, '0);
      next_cycle(); drive('0, '0, 0, 0);
      check("t4_c3_we", wb_we, 4'b0000);
    end

    // 4b: flush is sampled at the edge, so the final stage still strobes in the flush cycle
    next_cycle(); drive(4'b1000, ch(3, 32'h4444_4444), 0, 0);
    next_cycle(); drive('0, '0, 0, 0);
    next_cycle(); drive('0, '0, 0, 1);
    check("t4b_flush_cycle_we", wb_we, 4'b1000);
    next_cycle(); drive('0, '0, 0, 0);
    check("t4b_after_we", wb_we, 4'b0000);

    // 5: back-to-back writes on ch0: bypass shows the youngest, write-back keeps order
    next_cycle(); drive(4'b0001, ch(0, 32'h11), 0, 0);
    next_cycle(); drive(4'b0001, ch(0, 32'h22), 0, 0);
    check("t5_c1_pending", pending, 8'h01);
    check("t5_c1_bypd",    byp_data[31:0], 32'h11);
    next_cycle(); drive('0, '0, 0, 0);
    check("t5_c2_pending", pending, 8'h02);
    check("t5_c2_bypd",    byp_data[31:0], 32'h22);
    check("t5_c2_we",      wb_we, 4'b0001);
    check("t5_c2_data",    wb_data[31:0], 32'h11);
    next_cycle(); drive('0, '0, 0, 0);
    check("t5_c3_we",      wb_we, 4'b0001);
    check("t5_c3_data",    wb_data[31:0], 32'h22);
    check("t5_c3_pending", pending, 8'h01);
    next_cycle(); drive('0, '0, 0, 0);
    check("t5_c4_we", wb_we, 4'b0000);

    // 6: DEPTH=1 / DEPTH=4 streaming, async reset mid-stream, restart, drain
    next_cycle();
    rst_b = 1'b0;
    stream(10);
    rst_b  = 1'b1;
    s_we   = 4'hF;
    s_data = {$urandom, $urandom, $urandom, $urandom};
    q1.delete();
    q4.delete();
    #1;
    check("t6_rst_d4_we",      d4_wb_we,     4'h0);
    check("t6_rst_d4_pending", d4_pending,   12'h000);
    check("t6_rst_d4_bypv",    d4_byp_valid, 4'h0);
    check("t6_rst_d1_we",      d1_wb_we,     4'h0);
    check("t6_rst_d1_pending", d1_pending,   4'h0);
    next_cycle();
    rst_b = 1'b0;
    s_we  = 4'h0;
    #1;
    check("t6_post_rst_d4_pending", d4_pending, 12'h000);
    check("t6_post_rst_d1_we",      d1_wb_we,   4'h0);
    next_cycle();
    stream(8);
    for (int c = 0; c < 6; c++) next_cycle();
    check("t6_d1_drained", q1.size(), 0);
    check("t6_d4_drained", q4.size(), 0);
    check("t6_idle_d4_pending", d4_pending, 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
